// File: rtl/pipelined_adder_seg_pkg.sv
// rtl/pipelined_adder_seg_pkg.sv - shared sizing, legality check and stage-register layout
package pipelined_adder_seg_pkg;

  // Flag bits sit above the three WIDTH-wide fields (sum | A | B').
  localparam int F_CARRY_OFS = 0;
  localparam int F_SUB_OFS   = 1;
  localparam int F_CMSB_OFS  = 2;
  localparam int F_VALID_OFS = 3;
  localparam int N_FLAGS     = 4;

  function automatic int calc_stages(input int width, input int seg);
    return width / seg;
  endfunction

  function automatic bit seg_legal(input int width, input int seg);
    return (seg > 0) && (width >= seg) && ((width % seg) == 0);
  endfunction

  function automatic int reg_width(input int width);
    return 3 * width + N_FLAGS;
  endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/ripple_seg.sv
// rtl/ripple_seg.sv - SEG-bit ripple-carry chain of full_adder cells
module ripple_seg #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           cin_i,
  output logic [SEG-1:0] s_o,
  output logic           cout_o,
  output logic           c_msb_in_o
);

  logic [SEG:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < SEG; i++) begin : g_bit
    full_adder u_fa (
      .a_i    (a_i[i]),
      .b_i    (b_i[i]),
      .cin_i  (carry[i]),
      .s_o    (s_o[i]),
      .cout_o (carry[i+1])
    );
  end

  assign cout_o     = carry[SEG];
  // Carry into the top bit of the segment; only the last stage's value feeds overflow.
  assign c_msb_in_o = carry[SEG-1];

endmodule

// File: rtl/pipelined_adder_seg.sv
// rtl/pipelined_adder_seg.sv - segment-pipelined adder/subtractor with valid/ready on both sides
module pipelined_adder_seg
  import pipelined_adder_seg_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int STAGES  = calc_stages(WIDTH, SEG);
  localparam int RW      = reg_width(WIDTH);
  localparam int LAST    = STAGES - 1;
  localparam int SUM_LSB = 0;
  localparam int A_LSB   = WIDTH;
  localparam int B_LSB   = 2 * WIDTH;
  localparam int CARRY_B = 3 * WIDTH + F_CARRY_OFS;
  localparam int SUB_B   = 3 * WIDTH + F_SUB_OFS;
  localparam int CMSB_B  = 3 * WIDTH + F_CMSB_OFS;
  localparam int VALID_B = 3 * WIDTH + F_VALID_OFS;

  if (!seg_legal(WIDTH, SEG)) begin : g_bad_cfg
    $error("pipelined_adder_seg: WIDTH must be a non-zero multiple of SEG");
  end

  logic [STAGES-1:0][RW-1:0] stage_q;
  logic [STAGES-1:0][RW-1:0] stage_d;
  logic [RW-1:0]             issue_word;
  logic                      adv;
  logic                      unused_last;

  assign out_valid = stage_q[LAST][VALID_B];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  // Bubbles enter as an all-zero word so idle stages carry no stale operands.
  always_comb begin
    issue_word = '0;
    if (in_valid) begin
      issue_word[A_LSB +: WIDTH] = in_a;
      issue_word[B_LSB +: WIDTH] = in_sub ? ~in_b : in_b;
      issue_word[CARRY_B]        = in_sub | in_cin;
      issue_word[SUB_B]          = in_sub;
      issue_word[VALID_B]        = 1'b1;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [RW-1:0]  src;
    logic [RW-1:0]  nxt;
    logic [SEG-1:0] seg_sum;
    logic           seg_cout;
    logic           seg_cmsb;

    if (k == 0) begin : g_first
      assign src = issue_word;
    end else begin : g_next
      assign src = stage_q[k-1];
    end

    ripple_seg #(.SEG(SEG)) u_seg (
      .a_i        (src[A_LSB + k*SEG +: SEG]),
      .b_i        (src[B_LSB + k*SEG +: SEG]),
      .cin_i      (src[CARRY_B]),
      .s_o        (seg_sum),
      .cout_o     (seg_cout),
      .c_msb_in_o (seg_cmsb)
    );

    always_comb begin
      nxt                           = src;
      nxt[SUM_LSB + k*SEG +: SEG]   = seg_sum;
      nxt[CARRY_B]                  = seg_cout;
      nxt[CMSB_B]                   = seg_cmsb;
    end

    assign stage_d[k] = nxt;
  end

  // A single advance enable freezes every stage together, bubbles included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else if (adv) begin
      stage_q <= stage_d;
    end
  end

  assign out_sum  = stage_q[LAST][SUM_LSB +: WIDTH];
  assign out_cout = stage_q[LAST][CARRY_B];
  assign out_ovf  = stage_q[LAST][CMSB_B] ^ stage_q[LAST][CARRY_B];

  assign unused_last = ^{stage_q[LAST][A_LSB +: 2*WIDTH], stage_q[LAST][SUB_B]};

endmodule

// File: tb/tb_pipelined_adder_seg.sv
// tb/tb_pipelined_adder_seg.sv - randomized self-checking bench over three adder configurations
module tb_pipelined_adder_seg;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  in_valid_v, in_ready_v, cin_v, sub_v;
  logic [2:0]  out_valid_v, out_ready_v, cout_v, ovf_v;
  logic [31:0] a_v [3];
  logic [31:0] b_v [3];
  logic [31:0] sum0;
  logic [15:0] sum1;
  logic [7:0]  sum2;

  int   widths [3] = '{32, 16, 8};
  int   stages [3] = '{4, 1, 8};
  exp_t q [$];
  exp_t none_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  bit          held_v = 1'b0;
  logic [31:0] held_sum;
  logic        held_c, held_o;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  pipelined_adder_seg #(.WIDTH(32), .SEG(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_a(a_v[0]), .in_b(b_v[0]), .in_cin(cin_v[0]), .in_sub(sub_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .out_sum(sum0),
    .out_cout(cout_v[0]), .out_ovf(ovf_v[0])
  );

  pipelined_adder_seg #(.WIDTH(16), .SEG(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_a(a_v[1][15:0]), .in_b(b_v[1][15:0]), .in_cin(cin_v[1]), .in_sub(sub_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .out_sum(sum1),
    .out_cout(cout_v[1]), .out_ovf(ovf_v[1])
  );

  pipelined_adder_seg #(.WIDTH(8), .SEG(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_a(a_v[2][7:0]), .in_b(b_v[2][7:0]), .in_cin(cin_v[2]), .in_sub(sub_v[2]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .out_sum(sum2),
    .out_cout(cout_v[2]), .out_ovf(ovf_v[2])
  );

  function automatic logic [31:0] get_sum(input int c);
    case (c)
      0:       return sum0;
      1:       return {16'h0, sum1};
      default: return {24'h0, sum2};
    endcase
  endfunction

  // Reference: plain modular arithmetic plus the textbook signed-overflow rule.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    exp_t        e;
    logic [32:0] full;
    logic [31:0] mask, am, bm;
    logic        c0;
    mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    am     = a & mask;
    bm     = (sub ? ~b : b) & mask;
    c0     = sub ? 1'b1 : cin;
    full   = {1'b0, am} + {1'b0, bm} + {32'd0, c0};
    e.sum  = full[31:0] & mask;
    e.cout = full[w];
    e.ovf  = (am[w-1] == bm[w-1]) && (e.sum[w-1] != am[w-1]);
    e.acc  = 0;
    return e;
  endfunction

  // One clock cycle on configuration c, entered and left at a falling edge.
  task automatic cycle(input int c, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic sub, input logic ordy, input bit use_ex,
                       input exp_t ex, input bit chk_lat, output bit acc, output logic rdy);
    exp_t        e;
    logic [31:0] s;
    in_valid_v[c]  = v;
    a_v[c]         = a;
    b_v[c]         = b;
    cin_v[c]       = cin;
    sub_v[c]       = sub;
    out_ready_v[c] = ordy;
    #1;
    s   = get_sum(c);
    rdy = in_ready_v[c];
    total++;
    if (in_ready_v[c] !== (!out_valid_v[c] || ordy)) begin
      bad++;
      $display("FAIL in_ready cfg%0d: got %b want %b", c, in_ready_v[c], (!out_valid_v[c] || ordy));
    end
    if (held_v) begin
      total++;
      if (out_valid_v[c] !== 1'b1 || {s, cout_v[c], ovf_v[c]} !== {held_sum, held_c, held_o}) begin
        bad++;
        $display("FAIL stall_hold cfg%0d: got v=%b %h/%b/%b want v=1 %h/%b/%b", c, out_valid_v[c],
                 s, cout_v[c], ovf_v[c], held_sum, held_c, held_o);
      end
    end
    held_v = 1'b0;
    if (out_valid_v[c] === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_valid cfg%0d: got out_valid=1 want 0 (nothing in flight)", c);
      end else begin
        e = q[0];
        total++;
        if (s !== e.sum) begin
          bad++;
          $display("FAIL sum cfg%0d: got %h want %h", c, s, e.sum);
        end
        total++;
        if (cout_v[c] !== e.cout) begin
          bad++;
          $display("FAIL cout cfg%0d: got %b want %b", c, cout_v[c], e.cout);
        end
        total++;
        if (ovf_v[c] !== e.ovf) begin
          bad++;
          $display("FAIL ovf cfg%0d: got %b want %b", c, ovf_v[c], e.ovf);
        end
        if (chk_lat) begin
          total++;
          if (cyc - e.acc !== stages[c] - 1) begin
            bad++;
            $display("FAIL latency cfg%0d: got %0d want %0d", c, cyc - e.acc, stages[c] - 1);
          end
        end
        if (ordy) begin
          void'(q.pop_front());
        end else begin
          held_v   = 1'b1;
          held_sum = s;
          held_c   = cout_v[c];
          held_o   = ovf_v[c];
        end
      end
    end
    acc = v && (in_ready_v[c] === 1'b1);
    if (acc) begin
      e     = use_ex ? ex : model(widths[c], a, b, cin, sub);
      e.acc = cyc + 1;
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic drain(input int c, input bit chk_lat);
    bit   acc;
    logic rdy;
    for (int i = 0; i < 64 && q.size() > 0; i++)
      cycle(c, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, none_e, chk_lat, acc, rdy);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout cfg%0d: got %0d pending want 0", c, q.size());
    end
    q.delete();
    repeat (4) cycle(c, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, none_e, 1'b0, acc, rdy);
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    in_valid_v  = '0;
    out_ready_v = '0;
    cin_v       = '0;
    sub_v       = '0;
    for (int i = 0; i < 3; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      total++;
      if (out_valid_v[c] !== 1'b0 || get_sum(c) !== 32'd0 || cout_v[c] !== 1'b0 || ovf_v[c] !== 1'b0) begin
        bad++;
        $display("FAIL reset_outputs cfg%0d: got v=%b s=%h c=%b o=%b want all 0", c, out_valid_v[c],
                 get_sum(c), cout_v[c], ovf_v[c]);
      end
      total++;
      if (in_ready_v[c] !== 1'b1) begin
        bad++;
        $display("FAIL reset_in_ready cfg%0d: got %b want 1", c, in_ready_v[c]);
      end
    end
    @(negedge clk);
    rst_n       = 1'b1;
    out_ready_v = '1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] ta [6] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'd5, 32'd7, 32'd1};
    logic [31:0] tb [6] = '{32'd1, 32'd1, 32'd1, 32'd7, 32'd5, 32'd2};
    logic        tc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        ts [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] xs [6] = '{32'h0, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'h2, 32'h4};
    logic        xc [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        xo [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_t        e;
    bit          acc;
    logic        rdy;
    for (int i = 0; i < 6; i++) begin
      e.sum  = xs[i];
      e.cout = xc[i];
      e.ovf  = xo[i];
      e.acc  = 0;
      cycle(0, 1'b1, ta[i], tb[i], tc[i], ts[i], 1'b1, 1'b1, e, 1'b1, acc, rdy);
    end
    drain(0, 1'b1);
  endtask

  task automatic test_back_to_back();
    bit   acc;
    logic rdy;
    for (int i = 0; i < 24; i++)
      cycle(0, 1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1, 1'b0, none_e, 1'b1, acc, rdy);
    drain(0, 1'b1);
  endtask

  task automatic test_backpressure();
    int          issued = 0;
    logic [31:0] ra, rb;
    logic        rc, rs;
    bit          acc;
    logic        rdy;
    ra = $urandom;
    rb = $urandom;
    rc = 1'($urandom);
    rs = 1'($urandom);
    for (int i = 0; i < 40 && (issued < 6 || q.size() > 0); i++) begin
      cycle(0, issued < 6, ra, rb, rc, rs, !(i >= 4 && i < 7), 1'b0, none_e, 1'b0, acc, rdy);
      if (i >= 4 && i < 7) begin
        total++;
        if (rdy !== 1'b0) begin
          bad++;
          $display("FAIL stall_in_ready step%0d: got %b want 0", i, rdy);
        end
      end
      if (acc) begin
        issued++;
        ra = $urandom;
        rb = $urandom;
        rc = 1'($urandom);
        rs = 1'($urandom);
      end
    end
    total++;
    if (issued != 6 || q.size() != 0) begin
      bad++;
      $display("FAIL backpressure_count: got issued=%0d pending=%0d want 6/0", issued, q.size());
    end
    drain(0, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit   acc;
    logic rdy;
    for (int i = 0; i < 3; i++)
      cycle(0, 1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1, 1'b0, none_e, 1'b0, acc, rdy);
    in_valid_v[0]  = 1'b0;
    out_ready_v[0] = 1'b0;
    rst_n          = 1'b0;
    #1;
    total++;
    if (out_valid_v[0] !== 1'b0 || sum0 !== 32'd0 || cout_v[0] !== 1'b0 || ovf_v[0] !== 1'b0) begin
      bad++;
      $display("FAIL midreset_outputs: got v=%b s=%h c=%b o=%b want all 0", out_valid_v[0], sum0,
               cout_v[0], ovf_v[0]);
    end
    total++;
    if (in_ready_v[0] !== 1'b1) begin
      bad++;
      $display("FAIL midreset_in_ready: got %b want 1", in_ready_v[0]);
    end
    q.delete();
    held_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) cycle(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, none_e, 1'b0, acc, rdy);
    cycle(0, 1'b1, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b0, none_e, 1'b1, acc, rdy);
    drain(0, 1'b1);
  endtask

  task automatic test_sweep(input int c, input int n);
    int          issued = 0;
    logic [31:0] ra, rb;
    logic        rc, rs;
    bit          v, acc;
    logic        rdy;
    ra = $urandom;
    rb = $urandom;
    rc = 1'($urandom);
    rs = 1'($urandom);
    for (int i = 0; i < 3 * n && issued < n; i++) begin
      v = ($urandom_range(4, 0) != 0);
      cycle(c, v, ra, rb, rc, rs, 1'b1, 1'b0, none_e, 1'b1, acc, rdy);
      if (acc) begin
        issued++;
        ra = $urandom;
        rb = $urandom;
        rc = 1'($urandom);
        rs = 1'($urandom);
      end
    end
    total++;
    if (issued != n) begin
      bad++;
      $display("FAIL sweep_issue cfg%0d: got %0d want %0d", c, issued, n);
    end
    drain(c, 1'b1);
  endtask

  initial begin
    none_e.sum  = '0;
    none_e.cout = 1'b0;
    none_e.ovf  = 1'b0;
    none_e.acc  = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_sweep(1, 10000);
    test_sweep(2, 10000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_adder_seg.md
# pipelined_adder_seg

Parametrised, segment-pipelined two's-complement adder/subtractor, the successor to the fixed 10-bit ripple-carry adder. Operands of WIDTH bits are added SEG bits per pipeline stage, with the carry registered between stages. Throughput is one operation per cycle. It sits on the datapath between operand-issue logic and result write-back and uses a valid/ready handshake on both sides. Add/subtract mode and signed-overflow detection are per operation.

## Interface
Parameters:
- WIDTH, 32, operand and result width; must be a multiple of SEG
- SEG, 8, bits added per pipeline stage; STAGES = WIDTH/SEG (SEG = WIDTH gives a single registered stage)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  carry-in, used in add mode only
- in_sub  in  1  1 = subtract (A − B), 0 = add (A + B + cin)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_sum  out  WIDTH  result
- out_cout  out  1  carry out of the MSB (in subtract mode, 1 = no borrow)
- out_ovf  out  1  signed overflow

## Operation
- Effective operands: B' = in_sub ? ~in_b : in_b. Carry-in c0 = in_sub ? 1 : in_cin. In subtract mode in_cin is ignored.
- Stage k (0..STAGES−1) adds segment k, bits [k·SEG +: SEG], of A and B' using the carry registered by stage k−1. Stage 0 uses c0.
- Each stage register holds:
  - valid bit
  - completed low result segments
  - not-yet-added high segments of A and B'
  - carry
  - mode bit
- The last stage register drives out_sum and out_cout directly.
- The last stage also records the carry into the MSB. out_ovf = carry_into_MSB XOR out_cout.
- Global advance: adv = !out_valid || out_ready. All stage registers load only when adv = 1. in_ready = adv.
- Transfer in: in_valid && in_ready at a rising edge. A stage is loaded with a bubble (valid = 0) when in_valid = 0.
- Transfer out: out_valid && out_ready at a rising edge.
- Results leave in acceptance order; nothing is dropped or duplicated.
- Bubbles are not compressed: a stall freezes the whole pipe, including empty stages.
- Arithmetic is modulo 2^WIDTH. out_sum equals (A + B' + c0) mod 2^WIDTH for all operand values.

## Timing
- Reset (async assert, sync-safe deassert on clk): all valid bits 0, all data/carry registers 0. Outputs after reset: out_valid = 0, out_sum = 0, out_cout = 0, out_ovf = 0, in_ready = 1.
- Latency: an operation accepted at edge t appears with out_valid = 1 after edge t+STAGES−1 when there is no stall. With SEG = WIDTH, the result is valid the cycle after acceptance.
- Throughput: one operation per cycle while out_ready = 1.
- Stall: out_valid = 1 and out_ready = 0 forces in_ready = 0, and every register holds. out_sum, out_cout and out_ovf stay stable until the transfer completes.
- Simultaneous output transfer and input acceptance in the same cycle is legal and required at full rate.
- When in_valid = 1 and in_ready = 0, the source holds its operands. The block must not sample them.
- out_ready = 1 with out_valid = 0 has no effect.
- Reset mid-operation discards all in-flight operations. No result is produced for them after reset.
- in_ready is combinational from out_valid and out_ready only; there is no path from in_valid.

## Structure
- Shared package holds:
  - STAGES derivation (WIDTH/SEG) and the WIDTH % SEG == 0 legality check, elaboration error on violation
  - the stage-register field layout constants
- Natural sub-module: ripple_seg, a SEG-bit ripple-carry chain built from the existing full_adder cells, with ports a, b, cin, s, cout, c_msb_in. Instantiate one per stage.
- The top level contains the stage registers, valid chain and adv logic only.

## Test plan
All cases use WIDTH = 32, SEG = 8, STAGES = 4 unless stated otherwise.
- Add with full carry: A = 0xFFFFFFFF, B = 0x00000001, cin = 0, add → out_sum = 0x00000000, cout = 1, ovf = 0, out_valid 3 cycles after acceptance.
- Signed overflow: A = 0x7FFFFFFF, B = 1, add → 0x80000000, cout = 0, ovf = 1. Also A = 0x80000000 − 1 (subtract) → 0x7FFFFFFF, cout = 1, ovf = 1.
- Subtract: A = 5, B = 7, sub, in_cin = 1 (ignored) → 0xFFFFFFFE, cout = 0, ovf = 0. Also A = 7, B = 5 → 0x00000002, cout = 1.
- Backpressure: issue 6 back-to-back random operations and hold out_ready = 0 for 3 cycles mid-stream. Required:
  - in_ready = 0 while stalled
  - outputs stable while stalled
  - all 6 results correct and in order
  - no extra out_valid pulses
- Reset mid-flight: accept 3 operations, then assert rst_n = 0 for 1 cycle before any result → all outputs 0, and no out_valid appears afterwards until new operations are accepted.
- Configuration sweep: SEG = WIDTH = 16 and SEG = 1, WIDTH = 8. Check 10k random operations against a reference model. Latency must equal STAGES − 1 cycles after acceptance.
